// File: rtl/am_pkg.sv
// Shared alignment-marker definitions for the 40GBASE-R receive lane stages
// (AM lock, deskew, lane reorder).
package am_pkg;

  localparam int unsigned BLOCK_W   = 66;
  localparam int unsigned LANE_N    = 4;
  localparam int unsigned AM_PERIOD = 16384;
  localparam int unsigned AM_INV_N  = 4;

  // Per-lane {M2, M1, M0}; M0 sits in the low byte to line up with data[25:2].
  localparam logic [LANE_N-1:0][23:0] AM_TBL = {
    24'h3D79A2,  // lane 3
    24'h9B65C5,  // lane 2
    24'hE6C4F0,  // lane 1
    24'h477690   // lane 0
  };

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCK   = 2'd2;

endpackage

// File: rtl/am_lock_lane_rx_if.sv
// Per-lane block stream into and out of the AM lock stage, with lock status.
interface am_lock_lane_rx_if #(
  parameter int unsigned BLOCK_W = 66,
  parameter int unsigned LANE_W  = 2
);
  logic               block_lock_i;
  logic               data_v_i;
  logic [BLOCK_W-1:0] data_i;
  logic               data_v_o;
  logic [BLOCK_W-1:0] data_o;
  logic               am_v_o;
  logic               am_lock_o;
  logic [LANE_W-1:0]  lane_id_o;

  modport master (
    output block_lock_i, data_v_i, data_i,
    input  data_v_o, data_o, am_v_o, am_lock_o, lane_id_o
  );

  modport slave (
    input  block_lock_i, data_v_i, data_i,
    output data_v_o, data_o, am_v_o, am_lock_o, lane_id_o
  );
endinterface

// File: rtl/am_match_rx.sv
// Combinational AM detector: sync header, M0..M2 against the lane table and
// M4..M6 as their inverse. BIP3/BIP7 are not inspected.
module am_match_rx
  import am_pkg::*;
#(
  parameter int unsigned LANE_W = $clog2(LANE_N)
) (
  input  logic               valid_i,
  input  logic [BLOCK_W-1:0] data_i,
  output logic               match_o,
  output logic [LANE_W-1:0]  match_id_o
);

  logic hdr_ok;
  logic inv_ok;

  assign hdr_ok = (data_i[1:0] == 2'b01);
  assign inv_ok = (data_i[57:34] == ~data_i[25:2]);

  always_comb begin
    match_o    = 1'b0;
    match_id_o = '0;
    for (int l = 0; l < int'(LANE_N); l++) begin
      if (data_i[25:2] == AM_TBL[l]) begin
        match_o    = valid_i & hdr_ok & inv_ok;
        match_id_o = LANE_W'(l);
      end
    end
  end

endmodule

// File: rtl/am_lock_lane_rx.sv
// Per-lane AM lock: find an AM, confirm it one period later, then track it and
// flag each accepted AM alongside the one-cycle-delayed block stream.
module am_lock_lane_rx
  import am_pkg::*;
#(
  parameter int unsigned BLOCK_W   = am_pkg::BLOCK_W,
  parameter int unsigned LANE_N    = am_pkg::LANE_N,
  parameter int unsigned LANE_W    = $clog2(LANE_N),
  parameter int unsigned AM_PERIOD = am_pkg::AM_PERIOD,
  parameter int unsigned AM_INV_N  = am_pkg::AM_INV_N,
  parameter int unsigned CNT_W     = $clog2(AM_PERIOD)
) (
  input logic               clk,
  input logic               nreset,
  am_lock_lane_rx_if.slave  bus
);

  localparam int unsigned INV_W = $clog2(AM_INV_N + 1);
  localparam logic [CNT_W-1:0] SLOT = CNT_W'(AM_PERIOD - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INV_W-1:0]   inv_q, inv_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic               am_v_q, am_v_d;
  logic               lock_q;
  logic               data_v_q;
  logic [BLOCK_W-1:0] data_q;

  logic              match;
  logic [LANE_W-1:0] match_id;
  logic              slot;
  logic              good;

  am_match_rx #(
    .LANE_W (LANE_W)
  ) u_match (
    .valid_i    (bus.data_v_i),
    .data_i     (bus.data_i),
    .match_o    (match),
    .match_id_o (match_id)
  );

  assign slot = bus.data_v_i && (cnt_q == SLOT);
  assign good = match && (match_id == lane_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    lane_d  = lane_q;
    am_v_d  = 1'b0;
    if (bus.data_v_i) begin
      cnt_d = slot ? '0 : cnt_q + 1'b1;
    end
    if (!bus.block_lock_i) begin
      state_d = ST_SEARCH;
      cnt_d   = '0;
      inv_d   = '0;
    end else if (bus.data_v_i) begin
      case (state_q)
        ST_SEARCH: begin
          if (match) begin
            lane_d  = match_id;
            cnt_d   = '0;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          // A failed confirmation is dropped, not retried as a new candidate.
          if (slot) begin
            if (good) begin
              state_d = ST_LOCK;
              am_v_d  = 1'b1;
              inv_d   = '0;
            end else begin
              state_d = ST_SEARCH;
            end
          end
        end
        ST_LOCK: begin
          if (slot) begin
            if (good) begin
              am_v_d = 1'b1;
              inv_d  = '0;
            end else if (inv_q == INV_W'(AM_INV_N - 1)) begin
              state_d = ST_SEARCH;
              inv_d   = '0;
            end else begin
              inv_d = inv_q + 1'b1;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= ST_SEARCH;
      cnt_q    <= '0;
      inv_q    <= '0;
      lane_q   <= '0;
      am_v_q   <= 1'b0;
      lock_q   <= 1'b0;
      data_v_q <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      inv_q    <= inv_d;
      lane_q   <= lane_d;
      am_v_q   <= am_v_d;
      lock_q   <= (state_d == ST_LOCK);
      data_v_q <= bus.data_v_i;
      data_q   <= bus.data_i;
    end
  end

  assign bus.data_v_o  = data_v_q;
  assign bus.data_o    = data_q;
  assign bus.am_v_o    = am_v_q;
  assign bus.am_lock_o = lock_q;
  assign bus.lane_id_o = lane_q;

endmodule

// File: doc/am_lock_lane_rx.md
Name: am_lock_lane_rx

Overview:
Per-lane alignment marker (AM) lock stage for the 40GBASE-R PCS receive path. It sits directly upstream of the per-lane deskew buffer and directly downstream of that lane's block sync.
- Finds the lane's AM, confirms it one period later, then tracks it.
- Produces a registered block stream, a per-block AM-valid strobe aligned with that stream, the lock status, and the detected logical lane id.
- The deskew stage uses the strobe to reset its skew counter. Marker blocks are still forwarded; the deskew stage discards them.

Parameters:
BLOCK_W, 66, block width including 2-bit sync header.
LANE_N, 4, number of PCS lanes / AM encodings.
LANE_W, $clog2(LANE_N), lane id width.
AM_PERIOD, 16384, blocks per AM period, AM block included; simulation uses 16.
AM_INV_N, 4, consecutive AM mismatches while locked that cause loss of lock.
CNT_W, $clog2(AM_PERIOD), block counter width.

Ports:
clk  in  1  clock.
nreset  in  1  synchronous, active-low reset.
block_lock_i  in  1  block sync lock from upstream; low forces SEARCH.
data_v_i  in  1  data_i valid this cycle (gearbox stall when low).
data_i  in  BLOCK_W  descrambler-bypassed 66b block; [1:0] sync header, [9:2] M0, [17:10] M1 … [65:58] BIP7.
data_v_o  out  1  data_o valid.
data_o  out  BLOCK_W  data_i delayed one cycle.
am_v_o  out  1  data_o is an accepted AM for this lane.
am_lock_o  out  1  lane AM lock.
lane_id_o  out  LANE_W  logical lane of the locked AM; valid when am_lock_o=1.

Behaviour:
- Reset (nreset=0 at posedge): all outputs 0, FSM=SEARCH, cnt=0, inv_cnt=0, lane_id=0. data_o is reset to 0.
- Latency: 1 cycle. data_v_o, data_o, am_v_o and am_lock_o are all registered from the same input cycle. am_v_o is never 1 while data_v_o=0.
- AM match (combinational, qualified by data_v_i):
  - sync header == 2'b01;
  - M0,M1,M2 equal a lane's table entry;
  - M4,M5,M6 equal the bitwise inverse of M0,M1,M2;
  - BIP3/BIP7 ignored.
  - Table: lane0 90,76,47; lane1 F0,C4,E6; lane2 C5,65,9B; lane3 A2,79,3D (hex).
  - Outputs: match and match_id.
- Counter: cnt increments only on data_v_i=1 blocks, wrapping at AM_PERIOD-1 -> 0. The expected slot is a valid block with cnt==AM_PERIOD-1.
- FSM:
  - SEARCH: a valid matching block sets lane_id=match_id, cnt=0 -> CHECK. am_v_o=0.
  - CHECK, at expected slot:
    - match with match_id==lane_id: -> LOCK, am_lock_o=1 and am_v_o=1 for this block, cnt=0.
    - otherwise: -> SEARCH, and this block is not re-evaluated as a candidate.
    - Non-slot blocks are never compared.
  - LOCK, at expected slot:
    - matching lane: am_v_o=1, inv_cnt=0, cnt=0.
    - mismatch (including a different lane's AM): inv_cnt++ and the block is forwarded with am_v_o=0. If inv_cnt reaches AM_INV_N, go -> SEARCH and clear am_lock_o on that same registered cycle.
    - Period timing is unchanged on a mismatch.
- block_lock_i=0 in any state: -> SEARCH next cycle, cnt=0, inv_cnt=0, am_lock_o=0. Data is still forwarded.
- data_v_i=0: FSM, counters and lane_id hold; data_v_o=0, am_v_o=0.
- am_lock_o is asserted only in LOCK. lane_id_o is held stable while locked.

Decomposition:
- Shared package am_pkg: LANE_N, AM_PERIOD, AM_INV_N, the per-lane M0/M1/M2 constant array, and the FSM state enum (SEARCH, CHECK, LOCK). The deskew and lane reorder stages reuse the same package.
- One sub-module, am_match_rx: purely combinational table compare (data_i -> match, match_id). It is reused by the TX AM insertion self-check.

Test Plan:
- Lane2 AM at blocks 3 and 19 (AM_PERIOD=16), all valid -> am_lock_o=1 and am_v_o=1 with block 19 on data_o, lane_id_o=2. Block 3 gives am_v_o=0.
- Lane1 AM then a lane3 AM at the next slot -> stays unlocked and returns to SEARCH. A lane1 AM 16 blocks after that restarts CHECK, then LOCK a period later.
- Locked on lane0, corrupt 3 consecutive slot AMs, then a good one -> am_lock_o stays 1 and inv_cnt clears. Corrupting 4 consecutive slots -> am_lock_o falls with the 4th slot block.
- Locked; data_v_i low for 5 cycles mid-period -> the next am_v_o arrives after exactly 16 valid blocks; data_v_o=0 during the stall.
- block_lock_i pulsed low while locked -> am_lock_o=0 next cycle; a fresh 2-AM sequence relocks.
- nreset asserted in LOCK -> all outputs 0 next cycle, then normal relock after release.
